// File: rtl/scan_pkg.sv
// Shared types and default sizing for the scan chain responder cell.
package scan_pkg;

    localparam int DEFAULT_NUM_IOS     = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        LATCH   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_sync_edge.sv
// Synchronizer, optional two-sample deglitch filter and rising-edge detect for one scan input.
// Optional feature: SCAN_RESPONDER_DEGLITCH_EN adds the filter (one extra cycle of latency).
module scan_sync_edge
    import scan_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic sync_o,
    output logic val_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   val_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef SCAN_RESPONDER_DEGLITCH_EN
    logic sample_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sync_o;
        end
    end

    // A new level is accepted only once two consecutive samples agree.
    assign val_o = (sync_o == sample_q) ? sync_o : val_q;
`else
    assign val_o = sync_o;
`endif

    // Resetting the delayed copy with the chain keeps reset release edge-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q <= 1'b0;
        end else begin
            val_q <= val_o;
        end
    end

    assign rise_o = val_o & ~val_q;

endmodule

// File: rtl/scan_responder.sv
// Scan chain responder cell: captures design outputs, shifts them through the chain, latches new inputs.
// Optional feature: SCAN_RESPONDER_DEGLITCH_EN enables the input deglitch filter in scan_sync_edge.
module scan_responder
    import scan_pkg::*;
#(
    parameter int NUM_IOS     = DEFAULT_NUM_IOS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_clk_in,
    input  logic               scan_data_in,
    input  logic               scan_select_in,
    input  logic               scan_latch_enable_in,
    input  logic [NUM_IOS-1:0] module_data_out,
    output logic               scan_clk_out,
    output logic               scan_select_out,
    output logic               scan_latch_enable_out,
    output logic               scan_data_out,
    output logic [NUM_IOS-1:0] module_data_in,
    output logic               frame_done,
    output logic               align_err
);

    localparam int                CNT_W   = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NUM_IOS - 1);

    logic clk_val,  clk_rise;
    logic sel_val,  sel_rise;
    logic lat_val,  lat_rise;
    logic data_val;
    logic unused_clk_val, unused_sel_val, unused_lat_val;
    logic unused_data_sync, unused_data_rise;

    scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset_n(reset_n), .din_i(scan_clk_in),
        .sync_o(scan_clk_out), .val_o(clk_val), .rise_o(clk_rise)
    );

    scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(clk), .reset_n(reset_n), .din_i(scan_select_in),
        .sync_o(scan_select_out), .val_o(sel_val), .rise_o(sel_rise)
    );

    scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
        .clk(clk), .reset_n(reset_n), .din_i(scan_latch_enable_in),
        .sync_o(scan_latch_enable_out), .val_o(lat_val), .rise_o(lat_rise)
    );

    // Data rides the same pipeline as scan_clk so it stays aligned with its shift edge.
    scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset_n(reset_n), .din_i(scan_data_in),
        .sync_o(unused_data_sync), .val_o(data_val), .rise_o(unused_data_rise)
    );

    assign unused_clk_val = clk_val;
    assign unused_sel_val = sel_val;
    assign unused_lat_val = lat_val;

    scan_state_e        state_q, state_d;
    logic [NUM_IOS-1:0] sr_q, sr_d;
    logic [NUM_IOS-1:0] mdi_q, mdi_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               err_q, err_d;

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        state_d   = IDLE;
        sr_d      = sr_q;
        mdi_d     = mdi_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = err_q;

        if (sel_rise) begin
            state_d   = CAPTURE;
            sr_d      = module_data_out;
            bit_cnt_d = '0;
        end else if (lat_rise) begin
            state_d = LATCH;
            mdi_d   = sr_q;
            if (bit_cnt_q != '0) begin
                err_d = 1'b1;
            end
        end else if (clk_rise) begin
            state_d   = SHIFT;
            sr_d      = {sr_q[NUM_IOS-2:0], data_val};
            bit_cnt_d = (bit_cnt_q == CNT_MAX) ? '0 : bit_cnt_q + CNT_W'(1);
        end

        // A shift edge losing to capture or latch is dropped and flagged.
        if (clk_rise && (sel_rise || lat_rise)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            mdi_q     <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            mdi_q     <= mdi_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
        end
    end

    assign scan_data_out  = sr_q[NUM_IOS-1];
    assign module_data_in = mdi_q;
    assign frame_done     = (state_q == LATCH);
    assign align_err      = err_q;

endmodule

// File: tb/tb_scan_responder.sv
// Directed bench for scan_responder: shift/latch, capture/shift-out, alignment, reset and glitch cases.
module tb_scan_responder;

`ifdef SCAN_RESPONDER_DEGLITCH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       reset_n;
    logic       scan_clk_in;
    logic       scan_data_in;
    logic       scan_select_in;
    logic       scan_latch_enable_in;
    logic [7:0] module_data_out;
    logic       scan_clk_out;
    logic       scan_select_out;
    logic       scan_latch_enable_out;
    logic       scan_data_out;
    logic [7:0] module_data_in;
    logic       frame_done;
    logic       align_err;

    int passed;
    int total;

    scan_responder #(.NUM_IOS(8), .SYNC_STAGES(2)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .scan_clk_in           (scan_clk_in),
        .scan_data_in          (scan_data_in),
        .scan_select_in        (scan_select_in),
        .scan_latch_enable_in  (scan_latch_enable_in),
        .module_data_out       (module_data_out),
        .scan_clk_out          (scan_clk_out),
        .scan_select_out       (scan_select_out),
        .scan_latch_enable_out (scan_latch_enable_out),
        .scan_data_out         (scan_data_out),
        .module_data_in        (module_data_in),
        .frame_done            (frame_done),
        .align_err             (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic shift_bit(input logic d);
        @(negedge clk);
        scan_data_in = d;
        scan_clk_in  = 1'b1;
        repeat (2) @(negedge clk);
        scan_clk_in  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) shift_bit(b[i]);
    endtask

    task automatic pulse_sel();
        @(negedge clk);
        scan_select_in = 1'b1;
        repeat (2) @(negedge clk);
        scan_select_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic pulse_lat();
        @(negedge clk);
        scan_latch_enable_in = 1'b1;
        repeat (2) @(negedge clk);
        scan_latch_enable_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        scan_clk_in = 1'b0; scan_data_in = 1'b0;
        scan_select_in = 1'b0; scan_latch_enable_in = 1'b0;
        module_data_out = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (module_data_in !== 8'h00) $display("FAIL reset_mdi: got %h expected 00", module_data_in); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done); else passed++;
        total++; if (align_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", align_err); else passed++;
        total++; if (scan_data_out !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", scan_data_out); else passed++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_shift_latch();
        shift_byte(8'hA5);
        @(negedge clk);
        scan_latch_enable_in = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        total++; if (module_data_in !== 8'h00) $display("FAIL a5_early: got %h expected 00", module_data_in); else passed++;
        @(negedge clk);
        total++; if (module_data_in !== 8'hA5) $display("FAIL a5_data: got %h expected a5", module_data_in); else passed++;
        total++; if (frame_done !== 1'b1) $display("FAIL a5_done_hi: got %b expected 1", frame_done); else passed++;
        @(negedge clk);
        total++; if (frame_done !== 1'b0) $display("FAIL a5_done_lo: got %b expected 0", frame_done); else passed++;
        total++; if (align_err !== 1'b0) $display("FAIL a5_err: got %b expected 0", align_err); else passed++;
        scan_latch_enable_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_shift_out();
        logic [7:0] cap;
        cap = 8'h3C;
        module_data_out = cap;
        pulse_sel();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (scan_data_out !== cap[7-i])
                $display("FAIL sdo_bit%0d: got %b expected %b", i, scan_data_out, cap[7-i]);
            else passed++;
            shift_bit(1'b0);
        end
        total++; if (scan_data_out !== 1'b0) $display("FAIL sdo_drained: got %b expected 0", scan_data_out); else passed++;
        total++; if (module_data_in !== 8'hA5) $display("FAIL sdo_hold_mdi: got %h expected a5", module_data_in); else passed++;
    endtask

    task automatic test_coincide();
        module_data_out = 8'h96;
        @(negedge clk);
        scan_data_in   = 1'b1;
        scan_select_in = 1'b1;
        scan_clk_in    = 1'b1;
        repeat (2) @(negedge clk);
        scan_select_in = 1'b0;
        scan_clk_in    = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        total++; if (dut.sr_q !== 8'h96) $display("FAIL coin_sr: got %h expected 96", dut.sr_q); else passed++;
        total++; if (dut.bit_cnt_q !== 3'd0) $display("FAIL coin_cnt: got %0d expected 0", dut.bit_cnt_q); else passed++;
        total++; if (align_err !== 1'b1) $display("FAIL coin_err: got %b expected 1", align_err); else passed++;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        @(negedge clk);
        scan_clk_in = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        total++; if (scan_clk_out !== 1'b1) $display("FAIL mid_clkout_pre: got %b expected 1", scan_clk_out); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (module_data_in !== 8'h00) $display("FAIL mid_mdi: got %h expected 00", module_data_in); else passed++;
        total++; if (align_err !== 1'b0) $display("FAIL mid_err: got %b expected 0", align_err); else passed++;
        total++; if (scan_clk_out !== 1'b0) $display("FAIL mid_clkout: got %b expected 0", scan_clk_out); else passed++;
        total++; if (dut.sr_q !== 8'h00) $display("FAIL mid_sr: got %h expected 00", dut.sr_q); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL mid_done: got %b expected 0", frame_done); else passed++;
        scan_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        total++; if (dut.bit_cnt_q !== 3'd0) $display("FAIL mid_no_spurious: got cnt %0d expected 0", dut.bit_cnt_q); else passed++;
        shift_byte(8'hFF);
        pulse_lat();
        total++; if (module_data_in !== 8'hFF) $display("FAIL mid_ff_data: got %h expected ff", module_data_in); else passed++;
        total++; if (align_err !== 1'b0) $display("FAIL mid_ff_err: got %b expected 0", align_err); else passed++;
    endtask

    task automatic test_misalign();
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        pulse_lat();
        total++; if (module_data_in !== 8'hF6) $display("FAIL mis_data: got %h expected f6", module_data_in); else passed++;
        total++; if (align_err !== 1'b1) $display("FAIL mis_err: got %b expected 1", align_err); else passed++;
        module_data_out = 8'h3C;
        pulse_sel();
        shift_byte(8'h5A);
        pulse_lat();
        total++; if (module_data_in !== 8'h5A) $display("FAIL mis_next_data: got %h expected 5a", module_data_in); else passed++;
        total++; if (align_err !== 1'b1) $display("FAIL mis_sticky: got %b expected 1", align_err); else passed++;
    endtask

    task automatic test_glitch();
        logic [7:0] exp_sr;
        logic [2:0] exp_cnt;
`ifdef SCAN_RESPONDER_DEGLITCH_EN
        exp_sr  = 8'h00;
        exp_cnt = 3'd0;
`else
        exp_sr  = 8'h01;
        exp_cnt = 3'd1;
`endif
        module_data_out = 8'h00;
        pulse_sel();
        @(negedge clk);
        scan_data_in = 1'b1;
        @(negedge clk);
        scan_clk_in = 1'b1;
        @(negedge clk);
        scan_clk_in = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        total++; if (dut.sr_q !== exp_sr) $display("FAIL glitch_sr: got %h expected %h", dut.sr_q, exp_sr); else passed++;
        total++; if (dut.bit_cnt_q !== exp_cnt) $display("FAIL glitch_cnt: got %0d expected %0d", dut.bit_cnt_q, exp_cnt); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_shift_latch();
        test_shift_out();
        test_coincide();
        test_reset_midframe();
        test_misalign();
        test_glitch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scan_responder.md
SCAN_RESPONDER -- requirements
Module: scan_responder

Interface
REQ-001 The block SHALL provide parameter NUM_IOS, default 8, giving the number of design I/Os per chain cell.
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, giving the synchronizer depth on every scan input (minimum 2).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and reset_n.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning:
- clk  in  1  system clock; frequency at least 4x scan_clk_in.
- reset_n  in  1  asynchronous active-low reset.
- scan_clk_in  in  1  chain shift clock from the upstream cell or controller.
- scan_data_in  in  1  serial data from upstream.
- scan_select_in  in  1  capture request; a rising edge loads design outputs.
- scan_latch_enable_in  in  1  update request; a rising edge drives the shifted data to the design.
- module_data_out  in  NUM_IOS  outputs of the attached user design.
- scan_clk_out, scan_select_out, scan_latch_enable_out  out  1 each  synchronized copies forwarded downstream.
- scan_data_out  out  1  serial data to downstream, equal to sr[NUM_IOS-1].
- module_data_in  out  NUM_IOS  held inputs to the user design.
- frame_done  out  1  one-cycle pulse on each latch update.
- align_err  out  1  sticky flag for a misaligned frame.

Function
REQ-005 Each scan input SHALL pass through SYNC_STAGES flops, and edges SHALL be detected by comparing the last synchronizer stage with a one-cycle delayed copy.
REQ-006 The FSM SHALL have four states: IDLE, CAPTURE, SHIFT and LATCH, and it SHALL default to IDLE.
REQ-007 From any state, a scan_select rising edge SHALL enter CAPTURE for one cycle, and the block SHALL load sr <= module_data_out and clear bit_cnt.
REQ-008 A scan_clk rising edge SHALL enter SHIFT for one cycle, and the block SHALL perform sr <= {sr[NUM_IOS-2:0], scan_data_in_sync} and bit_cnt <= bit_cnt+1 modulo NUM_IOS.
REQ-009 A scan_latch_enable rising edge SHALL enter LATCH for one cycle, and the block SHALL perform module_data_in <= sr and pulse frame_done.
REQ-010 The block SHALL return to IDLE in the cycle after CAPTURE, SHIFT or LATCH unless another edge is detected in that cycle.
REQ-011 Edge priority when edges coincide SHALL be CAPTURE, then LATCH, then SHIFT; the shift edge SHALL be dropped, and align_err SHALL be set.
REQ-012 An input transition sampled at clk edge N SHALL update sr/module_data_in at edge N+SYNC_STAGES.
REQ-013 On LATCH, if bit_cnt != 0, the block SHALL set align_err; align_err SHALL clear only on reset.
REQ-014 The bit counter SHALL wrap from NUM_IOS-1 to 0 silently, so that any whole-byte multiple of shifts is legal.
REQ-015 scan_data_out SHALL be the MSB of sr, so that the first bit shifted in leaves the cell first after NUM_IOS further shifts.
REQ-016 The forwarded scan_clk_out, scan_select_out and scan_latch_enable_out SHALL be the last synchronizer stage, so downstream sees the same ordering.
REQ-017 module_data_in SHALL hold its value between LATCH events, and CAPTURE and SHIFT SHALL NOT disturb it.

Reset
REQ-018 While reset_n is low, the block SHALL clear sr, module_data_in, bit_cnt, all synchronizer and edge flops, frame_done and align_err, and SHALL force the state to IDLE.
REQ-019 Deasserting reset_n mid-frame SHALL NOT produce a spurious edge, because the edge-detect flops reset to 0 with the synchronizers.

Configuration
REQ-020 With SCAN_RESPONDER_DEGLITCH_EN defined, each synchronized scan input SHALL be accepted only after two consecutive equal samples, adding one cycle latency (N+SYNC_STAGES+1).
REQ-021 Without SCAN_RESPONDER_DEGLITCH_EN, the block SHALL omit the filter and latency SHALL be N+SYNC_STAGES.

Structure
REQ-022 Package scan_pkg SHALL hold the FSM state enum and the default NUM_IOS and SYNC_STAGES constants.
REQ-023 The synchronizer, optional deglitch filter and edge detect SHALL be one sub-module, scan_sync_edge, instantiated once per scan input.

Verification
REQ-024 The bench SHALL shift in 8 bits MSB-first of 0xA5 and then pulse latch, and SHALL require module_data_in==0xA5, frame_done high for 1 cycle, and align_err==0.
REQ-025 The bench SHALL set module_data_out=0x3C, pulse select, and apply 8 scan_clk edges with scan_data_in=0, and SHALL require scan_data_out sequence 0,0,1,1,1,1,0,0.
REQ-026 The bench SHALL apply 5 shifts and then latch, and SHALL require align_err=1 and that it remains set after a subsequent correct 8-shift frame.
REQ-027 The bench SHALL raise select and scan_clk in the same clk cycle, and SHALL require sr==module_data_out, bit_cnt==0 and align_err=1.
REQ-028 The bench SHALL pulse reset_n low after 4 of 8 shifts, and SHALL require all outputs to be 0 and the next full 0xFF frame to latch 0xFF.
REQ-029 The bench SHALL apply a 1-cycle glitch on scan_clk_in with SCAN_RESPONDER_DEGLITCH_EN defined, and SHALL require no shift; without the macro, it SHALL require exactly one shift.
